vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator with a scaled framebuffer address generator. It owns its own horizontal and vertical counters. From them it produces polarity-configurable hsync/vsync, display-enable, line and frame strobes, and the read address for a character/cell framebuffer. That framebuffer is mapped into a positionable window, and each memory cell covers a 2^SCALE_LOG2 × 2^SCALE_LOG2 block of screen pixels. It sits between the pixel-clock-enable source and the framebuffer RAM / colour output stage of the VGA controller.

---
 rtl/vga_timing_gen.sv | 126 ++++++++++++
 tb/tb_vga_timing_gen.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v counters, polarity-configurable syncs,
// display enable, line/frame strobes and a scaled window framebuffer address.
`timescale 1ns/1ps

module vga_timing_gen #(
  parameter int   H_ACTIVE   = 640,
  parameter int   H_FP       = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BP       = 48,
  parameter int   V_ACTIVE   = 480,
  parameter int   V_FP       = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BP       = 33,
  parameter logic HSYNC_POL  = 1'b0,
  parameter logic VSYNC_POL  = 1'b0,
  parameter int   WIN_X      = 256,
  parameter int   WIN_Y      = 112,
  parameter int   WIN_W      = 16,
  parameter int   WIN_H      = 32,
  parameter int   SCALE_LOG2 = 3,
  parameter int   ADDR_W     = $clog2(WIN_W * WIN_H),
  localparam int  H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  HW         = $clog2(H_TOTAL),
  localparam int  VW         = $clog2(V_TOTAL)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  output logic [HW-1:0]     hcnt,
  output logic [VW-1:0]     vcnt,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              win_active,
  output logic [ADDR_W-1:0] addr,
  output logic              line_start,
  output logic              frame_start
);

  localparam int X_SPAN_I = WIN_W << SCALE_LOG2;
  localparam int Y_SPAN_I = WIN_H << SCALE_LOG2;

  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_porch
    $error("vga_timing_gen: porch and sync widths must be non-zero");
  end
  if (WIN_X + X_SPAN_I > H_ACTIVE || WIN_Y + Y_SPAN_I > V_ACTIVE) begin : g_bad_window
    $error("vga_timing_gen: window exceeds the active area");
  end

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_LO  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_HI  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_LO  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_HI  = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [HW-1:0] WX_LO  = HW'(WIN_X);
  localparam logic [VW-1:0] WY_LO  = VW'(WIN_Y);
  localparam logic [HW-1:0] X_SPAN = HW'(X_SPAN_I);
  localparam logic [VW-1:0] Y_SPAN = VW'(Y_SPAN_I);
  localparam logic [ADDR_W-1:0] WIN_W_A = ADDR_W'(WIN_W);

  // Internal raster position, one pixel tick ahead of the registered outputs.
  logic [HW-1:0] h;
  logic [VW-1:0] v;

  logic [HW:0]       dx;
  logic [VW:0]       dy;
  logic              in_x, in_y;
  logic              hsync_n, vsync_n, de_n, win_n;
  logic [ADDR_W-1:0] cell_x, cell_y, addr_n;

  // The extra MSB of dx/dy is the borrow, i.e. "left of / above the window".
  always_comb begin
    dx      = {1'b0, h} - {1'b0, WX_LO};
    dy      = {1'b0, v} - {1'b0, WY_LO};
    in_x    = !dx[HW] && (dx[HW-1:0] < X_SPAN);
    in_y    = !dy[VW] && (dy[VW-1:0] < Y_SPAN);
    win_n   = in_x && in_y;
    cell_x  = ADDR_W'(dx[HW-1:0] >> SCALE_LOG2);
    cell_y  = ADDR_W'(dy[VW-1:0] >> SCALE_LOG2);
    addr_n  = win_n ? (cell_y * WIN_W_A + cell_x) : '0;
    hsync_n = ((h >= HS_LO) && (h < HS_HI)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_n = ((v >= VS_LO) && (v < VS_HI)) ? VSYNC_POL : ~VSYNC_POL;
    de_n    = (h < H_ACT) && (v < V_ACT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h           <= '0;
      v           <= '0;
      hcnt        <= '0;
      vcnt        <= '0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      de          <= 1'b0;
      win_active  <= 1'b0;
      addr        <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        hcnt        <= h;
        vcnt        <= v;
        hsync       <= hsync_n;
        vsync       <= vsync_n;
        de          <= de_n;
        win_active  <= win_n;
        addr        <= addr_n;
        line_start  <= (h == '0);
        frame_start <= (h == '0) && (v == '0);
        if (h == H_LAST) begin
          h <= '0;
          v <= (v == V_LAST) ? '0 : v + 1'b1;
        end else begin
          h <= h + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a full-size instance, a short-frame
// instance for window/frame timing, and a tiny instance against a model.
`timescale 1ns/1ps

module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // full-size 640x480 instance
  logic       rst_a = 1'b1, en_a = 1'b0;
  logic [9:0] hcnt_a, vcnt_a;
  logic       hsync_a, vsync_a, de_a, win_a, ls_a, fs_a;
  logic [8:0] addr_a;

  vga_timing_gen u_dut (
    .clk(clk), .rst(rst_a), .pix_en(en_a), .hcnt(hcnt_a), .vcnt(vcnt_a),
    .hsync(hsync_a), .vsync(vsync_a), .de(de_a), .win_active(win_a),
    .addr(addr_a), .line_start(ls_a), .frame_start(fs_a)
  );

  // same line timing, 46-line frame, 16x4 cell window at (256,2)
  logic       rst_m = 1'b1, en_m = 1'b0;
  logic [9:0] hcnt_m;
  logic [5:0] vcnt_m;
  logic       hsync_m, vsync_m, de_m, win_m, ls_m, fs_m;
  logic [5:0] addr_m;

  vga_timing_gen #(
    .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(2), .WIN_Y(2), .WIN_H(4)
  ) u_mid (
    .clk(clk), .rst(rst_m), .pix_en(en_m), .hcnt(hcnt_m), .vcnt(vcnt_m),
    .hsync(hsync_m), .vsync(vsync_m), .de(de_m), .win_active(win_m),
    .addr(addr_m), .line_start(ls_m), .frame_start(fs_m)
  );

  // tiny 12x7 raster, positive syncs, 4x2 unscaled window at origin
  logic       rst_s = 1'b1, en_s = 1'b0;
  logic [3:0] hcnt_s;
  logic [2:0] vcnt_s;
  logic       hsync_s, vsync_s, de_s, win_s, ls_s, fs_s;
  logic [2:0] addr_s;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
    .WIN_X(0), .WIN_Y(0), .WIN_W(4), .WIN_H(2), .SCALE_LOG2(0)
  ) u_small (
    .clk(clk), .rst(rst_s), .pix_en(en_s), .hcnt(hcnt_s), .vcnt(vcnt_s),
    .hsync(hsync_s), .vsync(vsync_s), .de(de_s), .win_active(win_s),
    .addr(addr_s), .line_start(ls_s), .frame_start(fs_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; en_a = 1'b1;
    repeat (5) tick();
    checks++;
    if ({hcnt_a, vcnt_a} !== 20'd0) begin
      errors++; $display("FAIL reset_cnt: got h=%0d v=%0d, want 0 0", hcnt_a, vcnt_a);
    end
    checks++;
    if ({hsync_a, vsync_a} !== 2'b11) begin
      errors++; $display("FAIL reset_sync: got hs=%b vs=%b, want 1 1", hsync_a, vsync_a);
    end
    checks++;
    if ({de_a, win_a, addr_a, ls_a, fs_a} !== 13'd0) begin
      errors++; $display("FAIL reset_flags: got de=%b win=%b addr=%0d ls=%b fs=%b, want all 0",
                         de_a, win_a, addr_a, ls_a, fs_a);
    end
    rst_a = 1'b0;
    tick();
    checks++;
    if ({hcnt_a, vcnt_a, de_a, ls_a, fs_a, addr_a, hsync_a} !== {10'd0, 10'd0, 3'b111, 9'd0, 1'b1}) begin
      errors++; $display("FAIL first_pixel: got h=%0d v=%0d de=%b ls=%b fs=%b addr=%0d hs=%b, want 0 0 1 1 1 0 1",
                         hcnt_a, vcnt_a, de_a, ls_a, fs_a, addr_a, hsync_a);
    end
    tick();
    checks++;
    if ({hcnt_a, ls_a, fs_a} !== {10'd1, 2'b00}) begin
      errors++; $display("FAIL second_pixel: got h=%0d ls=%b fs=%b, want 1 0 0", hcnt_a, ls_a, fs_a);
    end
  endtask

  task automatic test_line_timing();
    int n = 0, de_cnt = 0, hs_cnt = 0, ls_cnt = 0, hs_first = -1, hs_last = -1, seq_err = 0;
    en_a = 1'b1;
    while (!ls_a && n < 1000) begin
      tick(); n++;
    end
    checks++;
    if (!ls_a) begin
      errors++; $display("FAIL line_wait: no line_start within 1000 ticks, got ls=%b want 1", ls_a);
    end
    for (int i = 0; i < 800; i++) begin
      if (int'(hcnt_a) != i) seq_err++;
      if (de_a) de_cnt++;
      if (ls_a) ls_cnt++;
      if (!hsync_a) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(hcnt_a);
        hs_last = int'(hcnt_a);
      end
      tick();
    end
    checks++;
    if (seq_err != 0) begin
      errors++; $display("FAIL line_hcnt_seq: got %0d out-of-sequence pixels, want 0", seq_err);
    end
    checks++;
    if (de_cnt != 640) begin
      errors++; $display("FAIL line_de_count: got %0d, want 640", de_cnt);
    end
    checks++;
    if (hs_cnt != 96) begin
      errors++; $display("FAIL line_hsync_width: got %0d, want 96", hs_cnt);
    end
    checks++;
    if (hs_first != 656 || hs_last != 751) begin
      errors++; $display("FAIL line_hsync_span: got %0d..%0d, want 656..751", hs_first, hs_last);
    end
    checks++;
    if (ls_cnt != 1 || ls_a !== 1'b1) begin
      errors++; $display("FAIL line_period: got %0d strobes in 800 ticks, ls at 800=%b, want 1 and 1", ls_cnt, ls_a);
    end
  endtask

  task automatic test_sparse_enable();
    logic [32:0] prev;
    logic        was_en;
    int hold_err = 0, strobe_err = 0, last_ls = -1, periods = 0, period_err = 0;
    for (int k = 0; k < 7000; k++) begin
      en_a   = (k % 4 == 0);
      was_en = en_a;
      prev   = {hcnt_a, vcnt_a, hsync_a, vsync_a, de_a, win_a, addr_a};
      tick();
      if (!was_en) begin
        if ({hcnt_a, vcnt_a, hsync_a, vsync_a, de_a, win_a, addr_a} !== prev) hold_err++;
        if (ls_a || fs_a) strobe_err++;
      end
      if (ls_a) begin
        if (last_ls >= 0) begin
          periods++;
          if (k - last_ls != 3200) period_err++;
        end
        last_ls = k;
      end
    end
    en_a = 1'b0;
    checks++;
    if (hold_err != 0) begin
      errors++; $display("FAIL sparse_hold: got %0d changes after disabled edges, want 0", hold_err);
    end
    checks++;
    if (strobe_err != 0) begin
      errors++; $display("FAIL sparse_strobe_width: got %0d wide strobes, want 0", strobe_err);
    end
    checks++;
    if (periods < 1 || period_err != 0) begin
      errors++; $display("FAIL sparse_line_period: got %0d periods, %0d not 3200 clk, want >=1 and 0",
                         periods, period_err);
    end
  endtask

  task automatic test_midframe_reset();
    rst_a = 1'b1; en_a = 1'b1;
    tick();
    rst_a = 1'b0;
    repeat (4301) tick();
    checks++;
    if (hcnt_a !== 10'd300 || vcnt_a !== 10'd5) begin
      errors++; $display("FAIL midreset_pos: got h=%0d v=%0d, want 300 5", hcnt_a, vcnt_a);
    end
    rst_a = 1'b1;
    tick();
    checks++;
    if ({hcnt_a, vcnt_a, hsync_a, vsync_a, de_a, win_a, addr_a, ls_a, fs_a} !==
        {20'd0, 2'b11, 2'b00, 9'd0, 2'b00}) begin
      errors++; $display("FAIL midreset_values: got h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b, want 0 0 1 1 0 0 0",
                         hcnt_a, vcnt_a, hsync_a, vsync_a, de_a, ls_a, fs_a);
    end
    rst_a = 1'b0;
    tick();
    checks++;
    if ({hcnt_a, vcnt_a, de_a, fs_a, ls_a} !== {20'd0, 3'b111}) begin
      errors++; $display("FAIL midreset_restart: got h=%0d v=%0d de=%b fs=%b ls=%b, want 0 0 1 1 1",
                         hcnt_a, vcnt_a, de_a, fs_a, ls_a);
    end
    tick();
    checks++;
    if (hcnt_a !== 10'd1 || vcnt_a !== 10'd0 || fs_a !== 1'b0) begin
      errors++; $display("FAIL midreset_next: got h=%0d v=%0d fs=%b, want 1 0 0", hcnt_a, vcnt_a, fs_a);
    end
    en_a = 1'b0;
  endtask

  typedef struct { int h; int v; logic win; int addr; } pt_t;

  task automatic test_window_and_frame();
    pt_t pts[9];
    int pos_err = 0, vs_cnt = 0, vs_first = -1, vs_last = -1, fs_cnt = 0, de_cnt = 0, win_cnt = 0;
    int th, tv;
    pts[0] = '{256, 2, 1'b1, 0};
    pts[1] = '{263, 2, 1'b1, 0};
    pts[2] = '{264, 2, 1'b1, 1};
    pts[3] = '{383, 9, 1'b1, 15};
    pts[4] = '{256, 10, 1'b1, 16};
    pts[5] = '{383, 33, 1'b1, 63};
    pts[6] = '{384, 2, 1'b0, 0};
    pts[7] = '{255, 20, 1'b0, 0};
    pts[8] = '{256, 34, 1'b0, 0};
    rst_m = 1'b1; en_m = 1'b1;
    repeat (2) tick();
    rst_m = 1'b0;
    for (int t = 0; t < 36800; t++) begin
      tick();
      th = t % 800;
      tv = t / 800;
      if (int'(hcnt_m) != th || int'(vcnt_m) != tv) pos_err++;
      if (!vsync_m) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = t;
        vs_last = t;
      end
      if (fs_m) fs_cnt++;
      if (de_m) de_cnt++;
      if (win_m) win_cnt++;
      for (int p = 0; p < 9; p++) begin
        if (pts[p].h == th && pts[p].v == tv) begin
          checks++;
          if (win_m !== pts[p].win || int'(addr_m) != pts[p].addr) begin
            errors++; $display("FAIL addr_map(%0d,%0d): got win=%b addr=%0d, want win=%b addr=%0d",
                               th, tv, win_m, addr_m, pts[p].win, pts[p].addr);
          end
        end
      end
    end
    tick();
    en_m = 1'b0;
    checks++;
    if (pos_err != 0) begin
      errors++; $display("FAIL frame_raster_pos: got %0d position errors, want 0", pos_err);
    end
    checks++;
    if (vs_cnt != 1600 || vs_first != 33600 || vs_last != 35199) begin
      errors++; $display("FAIL frame_vsync: got %0d ticks from %0d to %0d, want 1600 from 33600 to 35199",
                         vs_cnt, vs_first, vs_last);
    end
    checks++;
    if (fs_cnt != 1 || fs_m !== 1'b1 || hcnt_m !== 10'd0 || vcnt_m !== 6'd0) begin
      errors++; $display("FAIL frame_period: got %0d strobes in frame, fs at 36800=%b h=%0d v=%0d, want 1 1 0 0",
                         fs_cnt, fs_m, hcnt_m, vcnt_m);
    end
    checks++;
    if (de_cnt != 25600 || win_cnt != 4096) begin
      errors++; $display("FAIL frame_area: got de=%0d win=%0d, want 25600 4096", de_cnt, win_cnt);
    end
  endtask

  task automatic test_small_model();
    int mh = 0, mv = 0, enabled = 0, fs_cnt = 0, shown = 0;
    logic        en_now;
    logic [3:0]  e_h;
    logic [2:0]  e_v;
    logic        e_hs, e_vs, e_de, e_win, e_ls, e_fs;
    logic [2:0]  e_addr;
    rst_s = 1'b1; en_s = 1'b1;
    tick();
    rst_s = 1'b0;
    e_h = '0; e_v = '0; e_hs = 1'b0; e_vs = 1'b0; e_de = 1'b0; e_win = 1'b0; e_addr = '0;
    for (int k = 0; enabled < 252 && k < 1000; k++) begin
      en_now = (k % 3 != 2);
      en_s = en_now;
      tick();
      e_ls = 1'b0; e_fs = 1'b0;
      if (en_now) begin
        enabled++;
        e_h    = 4'(mh);
        e_v    = 3'(mv);
        e_ls   = (mh == 0);
        e_fs   = (mh == 0 && mv == 0);
        e_hs   = (mh >= 9 && mh < 11);
        e_vs   = (mv == 5);
        e_de   = (mh < 8 && mv < 4);
        e_win  = (mh < 4 && mv < 2);
        e_addr = e_win ? 3'(mv * 4 + mh) : 3'd0;
        if (mh == 11) begin
          mh = 0;
          mv = (mv == 6) ? 0 : mv + 1;
        end else begin
          mh = mh + 1;
        end
      end
      if (fs_s) fs_cnt++;
      checks++;
      if ({hcnt_s, vcnt_s, hsync_s, vsync_s, de_s, win_s, addr_s, ls_s, fs_s} !==
          {e_h, e_v, e_hs, e_vs, e_de, e_win, e_addr, e_ls, e_fs}) begin
        errors++;
        if (shown < 10) begin
          shown++;
          $display("FAIL small_model clk %0d: got h=%0d v=%0d hs=%b vs=%b de=%b win=%b a=%0d ls=%b fs=%b, want h=%0d v=%0d hs=%b vs=%b de=%b win=%b a=%0d ls=%b fs=%b",
                   k, hcnt_s, vcnt_s, hsync_s, vsync_s, de_s, win_s, addr_s, ls_s, fs_s,
                   e_h, e_v, e_hs, e_vs, e_de, e_win, e_addr, e_ls, e_fs);
        end
      end
    end
    en_s = 1'b0;
    checks++;
    if (fs_cnt != 3 || enabled != 252) begin
      errors++; $display("FAIL small_frame_count: got %0d frame strobes over %0d ticks, want 3 over 252", fs_cnt, enabled);
    end
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_sparse_enable();
    test_midframe_reset();
    test_window_and_frame();
    test_small_model();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
